// File: rtl/result_hex_tx.sv
// Formats two captured result bytes as ASCII hex plus a line ending and feeds them to a UART tx.
// Optional: define RESULT_PREFIX_EN to start every message with '='.
module result_hex_tx #(
  parameter int unsigned HEX_UPPER = 1,
  parameter int unsigned EOL_CRLF  = 1
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic [7:0] res_data1,
  input  logic       res_rdy1,
  input  logic [7:0] res_data2,
  input  logic       res_rdy2,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_data_rdy,
  output logic       fmt_busy,
  output logic       overrun
);

`ifdef RESULT_PREFIX_EN
  localparam int unsigned PreLen = 1;
`else
  localparam int unsigned PreLen = 0;
`endif
  localparam int unsigned EolLen   = (EOL_CRLF != 0) ? 2 : 1;
  localparam int unsigned NumChars = PreLen + 4 + EolLen;
  localparam logic [2:0]  LastIdx  = 3'(NumChars - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StAck, StDrain} state_e;

  state_e     state_q, state_d;
  logic [7:0] slot1_q, slot1_d, slot2_q, slot2_d;
  logic       valid1_q, valid1_d, valid2_q, valid2_d;
  logic [7:0] buf1_q, buf1_d, buf2_q, buf2_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_rdy_q, tx_rdy_d;
  logic       overrun_q, overrun_d;
  logic [2:0] pos;
  logic [7:0] cur_char;
  logic       clr_valid;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)           return 8'h30 + {4'h0, n};
    else if (HEX_UPPER != 0) return 8'h37 + {4'h0, n};
    else                     return 8'h57 + {4'h0, n};
  endfunction

  // Character selected by the current index, prefix removed before decoding.
  always_comb begin
    pos      = idx_q - 3'(PreLen);
    cur_char = 8'h0A;
    case (pos)
      3'd0:    cur_char = hex_char(buf1_q[7:4]);
      3'd1:    cur_char = hex_char(buf1_q[3:0]);
      3'd2:    cur_char = hex_char(buf2_q[7:4]);
      3'd3:    cur_char = hex_char(buf2_q[3:0]);
      3'd4:    cur_char = (EOL_CRLF != 0) ? 8'h0D : 8'h0A;
      default: cur_char = 8'h0A;
    endcase
`ifdef RESULT_PREFIX_EN
    if (idx_q == 3'd0) cur_char = 8'h3D;
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = 1'b0;
    overrun_d = overrun_q;
    slot1_d   = slot1_q;
    slot2_d   = slot2_q;
    // LOAD empties both slots, so a pulse in that cycle is a fresh capture.
    clr_valid = (state_q == StLoad);
    valid1_d  = valid1_q & ~clr_valid;
    valid2_d  = valid2_q & ~clr_valid;

    if (res_rdy1) begin
      if (valid1_q && !clr_valid) begin
        overrun_d = 1'b1;
      end else begin
        slot1_d  = res_data1;
        valid1_d = 1'b1;
      end
    end
    if (res_rdy2) begin
      if (valid2_q && !clr_valid) begin
        overrun_d = 1'b1;
      end else begin
        slot2_d  = res_data2;
        valid2_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (valid1_q && valid2_q) state_d = StLoad;
      end
      StLoad: begin
        buf1_d  = slot1_q;
        buf2_d  = slot2_q;
        idx_d   = 3'd0;
        state_d = StSend;
      end
      StSend: begin
        if (!tx_busy) begin
          tx_data_d = cur_char;
          tx_rdy_d  = 1'b1;
          state_d   = StAck;
        end
      end
      // Gives the UART a cycle to raise busy before it is trusted.
      StAck: state_d = StDrain;
      StDrain: begin
        if (!tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= StIdle;
      slot1_q   <= 8'h00;
      slot2_q   <= 8'h00;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      buf1_q    <= 8'h00;
      buf2_q    <= 8'h00;
      idx_q     <= 3'd0;
      tx_data_q <= 8'h00;
      tx_rdy_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot1_q   <= slot1_d;
      slot2_q   <= slot2_d;
      valid1_q  <= valid1_d;
      valid2_q  <= valid2_d;
      buf1_q    <= buf1_d;
      buf2_q    <= buf2_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_rdy_q;
  assign fmt_busy    = (state_q != StIdle);
  assign overrun     = overrun_q;

endmodule
